// File: rtl/alu_pkg.sv
// Shared definitions for the iterative LEGv8 ALU.
//   OP_*          : ALUControl encodings (unchanged from the combinational ALU,
//                   plus MUL/UDIV/UREM)
//   state_t       : sequencer states
//   is_iterative  : op needs the multi-cycle multiply/divide datapath
//   is_div        : op uses the restoring divider rather than the multiplier
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_PASSA = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_UDIV  = 4'b1010;
  localparam logic [3:0] OP_UREM  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_UDIV) || (op == OP_UREM);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_UDIV) || (op == OP_UREM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-step unsigned multiply (shift-add) / divide (restoring) engine.
//   clk, reset   : clock, asynchronous active-high reset
//   load_i       : capture operands and mode (div_i) for a new operation
//   step_i       : advance one iteration
//   div_i        : 1 = divide (a_i / b_i), 0 = multiply (a_i * b_i)
//   a_i, b_i     : operands, sampled on load_i
//   acc_next_o   : value the accumulator takes on the next step
//                  (running product for MUL, partial remainder for DIV)
//   sh_next_o    : value the shift register takes on the next step
//                  (quotient bits for DIV)
// The next-step values are exported so the caller can capture the final
// iteration's outcome on the same edge that performs it.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         div_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] acc_next_o,
  output logic [N-1:0] sh_next_o
);

  logic         div_q;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] sh_q, sh_d;
  logic [N-1:0] opnd_q, opnd_d;
  logic [N:0]   rem_sh;
  logic         fits;

  // MUL: sh = multiplier (consumed LSB first), opnd = multiplicand (shifted left).
  // DIV: sh = dividend shifting out MSB first while quotient bits shift in,
  //      opnd = divisor, acc = partial remainder.
  always_comb begin
    rem_sh = {acc_q, sh_q[N-1]};
    fits   = rem_sh[N] | (rem_sh[N-1:0] >= opnd_q);
    acc_d  = acc_q;
    sh_d   = sh_q;
    opnd_d = opnd_q;
    if (div_q) begin
      // True difference is always < divisor, so N bits suffice.
      acc_d = fits ? (rem_sh[N-1:0] - opnd_q) : rem_sh[N-1:0];
      sh_d  = {sh_q[N-2:0], fits};
    end else begin
      acc_d  = acc_q + (sh_q[0] ? opnd_q : '0);
      sh_d   = {1'b0, sh_q[N-1:1]};
      opnd_d = {opnd_q[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= 1'b0;
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
    end else if (load_i) begin
      div_q  <= div_i;
      acc_q  <= '0;
      sh_q   <= div_i ? a_i : b_i;
      opnd_q <= div_i ? b_i : a_i;
    end else if (step_i) begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc_next_o = acc_d;
  assign sh_next_o  = sh_d;

endmodule

// File: rtl/alu_iter.sv
// Iterative LEGv8 execute-stage ALU with start/busy/done handshake.
//   clk, reset         : clock, asynchronous active-high reset
//   start              : request, accepted only while idle
//   a, b, ALUControl   : operands and op, sampled on the accepting edge
//   result             : registered result, held until the next completion
//   zero, negative     : derived from the result register
//   carry, overflow    : registered flags (ADD/SUB only, else 0)
//   busy               : high in RUN and DONE
//   done               : one-cycle pulse in DONE
// Single-cycle ops spend one cycle in RUN; MUL/UDIV/UREM with b!=0 spend N.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(N + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [N-1:0]  result_q, result_d;
  logic          carry_q, carry_d;
  logic          overflow_q, overflow_d;

  logic          md_load, md_step;
  logic [N-1:0]  md_acc, md_sh;

  logic [N:0]    sum_ext, diff_ext;
  logic [N-1:0]  op_res;
  logic          op_c, op_v;

  muldiv_iter #(.N(N)) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .load_i     (md_load),
    .step_i     (md_step),
    .div_i      (is_div(ALUControl)),
    .a_i        (a),
    .b_i        (b),
    .acc_next_o (md_acc),
    .sh_next_o  (md_sh)
  );

  // Final-cycle result and flags, evaluated from the latched operands.
  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};
    op_res   = '1;
    op_c     = 1'b0;
    op_v     = 1'b0;
    case (op_q)
      OP_AND:   op_res = a_q & b_q;
      OP_OR:    op_res = a_q | b_q;
      OP_ADD: begin
        op_res = sum_ext[N-1:0];
        op_c   = sum_ext[N];
        op_v   = (a_q[N-1] == b_q[N-1]) && (sum_ext[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        op_res = diff_ext[N-1:0];
        op_c   = diff_ext[N];
        op_v   = (a_q[N-1] != b_q[N-1]) && (diff_ext[N-1] != a_q[N-1]);
      end
      OP_PASSB: op_res = b_q;
      OP_PASSA: op_res = a_q;
      OP_MUL:   op_res = md_acc;
      OP_UDIV:  op_res = (b_q == '0) ? '1 : md_sh;
      OP_UREM:  op_res = (b_q == '0) ? a_q : md_acc;
      default:  op_res = '1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    md_load    = 1'b0;
    md_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = ALUControl;
          cnt_d   = (is_iterative(ALUControl) && (b != '0)) ? CW'(N) : CW'(1);
          md_load = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        md_step = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d   = op_res;
          carry_d    = op_c;
          overflow_d = op_v;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign zero     = ~|result_q;
  assign negative = result_q[N-1];
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

  logic clk = 1'b0;
  logic reset;

  logic        st64, z64, n64, c64, v64, bz64, dn64;
  logic [63:0] a64, b64, r64;
  logic [3:0]  op64;

  logic        st8, z8, n8, c8, v8, bz8, dn8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  op8;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [3:0] optab [12];

  always #5 clk = ~clk;

  alu_iter #(.N(64)) u64 (
    .clk(clk), .reset(reset), .start(st64), .a(a64), .b(b64), .ALUControl(op64),
    .result(r64), .zero(z64), .negative(n64), .carry(c64), .overflow(v64),
    .busy(bz64), .done(dn64)
  );

  alu_iter #(.N(8)) u8 (
    .clk(clk), .reset(reset), .start(st8), .a(a8), .b(b8), .ALUControl(op8),
    .result(r8), .zero(z8), .negative(n8), .carry(c8), .overflow(v8),
    .busy(bz8), .done(dn8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Behavioural reference: plain arithmetic on w-bit values.
  task automatic model(input int unsigned w, input logic [3:0] op,
                       input logic [63:0] av, input logic [63:0] bv,
                       output logic [63:0] r, output logic c, output logic v,
                       output int unsigned lat);
    logic [63:0] m, x, y;
    logic [64:0] s;
    m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    x   = av & m;
    y   = bv & m;
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[63:0] & m;
        c = s[w];
        v = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
      end
      4'b0110: begin
        r = (x - y) & m;
        c = (x >= y);
        v = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
      end
      4'b0111: r = y;
      4'b1000: r = x;
      4'b1001: begin r = (x * y) & m;               lat = (y != 0) ? w : 1; end
      4'b1010: begin r = (y == 0) ? m : x / y;      lat = (y != 0) ? w : 1; end
      4'b1011: begin r = (y == 0) ? x : x % y;      lat = (y != 0) ? w : 1; end
      default: r = m;
    endcase
  endtask

  task automatic drive(input bit w8, input logic s, input logic [3:0] op,
                       input logic [63:0] av, input logic [63:0] bv);
    if (w8) begin st8 = s; op8 = op; a8 = av[7:0]; b8 = bv[7:0]; end
    else begin st64 = s; op64 = op; a64 = av; b64 = bv; end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_reset(input bit w8);
    chk("rst_result",   w8 ? {56'd0, r8} : r64, 64'd0);
    chk("rst_zero",     w8 ? z8  : z64,  1);
    chk("rst_negative", w8 ? n8  : n64,  0);
    chk("rst_carry",    w8 ? c8  : c64,  0);
    chk("rst_overflow", w8 ? v8  : v64,  0);
    chk("rst_busy",     w8 ? bz8 : bz64, 0);
    chk("rst_done",     w8 ? dn8 : dn64, 0);
  endtask

  // One operation: issue in an IDLE cycle, scramble inputs after acceptance
  // (garble also keeps start high through RUN and DONE), then check latency,
  // outputs at done, and the return to idle with the result held.
  task automatic issue(input bit w8, input logic [3:0] op,
                       input logic [63:0] av, input logic [63:0] bv, input bit garble);
    int unsigned w, lat, n;
    logic [63:0] er;
    logic ec, ev;
    w = w8 ? 8 : 64;
    model(w, op, av, bv, er, ec, ev, lat);
    @(posedge clk); #1;
    chk("idle_busy", w8 ? bz8 : bz64, 0);
    drive(w8, 1'b1, op, av, bv);
    @(posedge clk); #1;
    drive(w8, garble, 4'($urandom), rnd64(), rnd64());
    chk("run_busy", w8 ? bz8 : bz64, 1);
    chk("run_done", w8 ? dn8 : dn64, 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (garble) drive(w8, 1'b1, 4'($urandom), rnd64(), rnd64());
    end while (!(w8 ? dn8 : dn64) && n < w + 4);
    chk("latency",  64'(n), 64'(lat));
    chk("done_busy", w8 ? bz8 : bz64, 1);
    chk("result",   w8 ? {56'd0, r8} : r64, er);
    chk("zero",     w8 ? z8 : z64, (er == 0));
    chk("negative", w8 ? n8 : n64, er[w-1]);
    chk("carry",    w8 ? c8 : c64, ec);
    chk("overflow", w8 ? v8 : v64, ev);
    @(posedge clk); #1;
    drive(w8, 1'b0, 4'($urandom), rnd64(), rnd64());
    chk("post_done",   w8 ? dn8 : dn64, 0);
    chk("post_busy",   w8 ? bz8 : bz64, 0);
    chk("post_result", w8 ? {56'd0, r8} : r64, er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    optab = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'h3, 4'h4, 4'hF};
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 4'h0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_reset(1'b0);
    check_reset(1'b1);
    reset = 1'b0;

    // Directed cases
    issue(1'b0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    issue(1'b0, 4'b0110, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    issue(1'b0, 4'b1001, 64'd7, 64'd6, 1'b1);
    issue(1'b1, 4'b1010, 64'd200, 64'd7, 1'b0);
    issue(1'b1, 4'b1011, 64'd200, 64'd7, 1'b0);
    issue(1'b1, 4'b1010, 64'h55, 64'd0, 1'b0);
    issue(1'b1, 4'b1011, 64'h55, 64'd0, 1'b0);
    issue(1'b1, 4'b0110, 64'h05, 64'h09, 1'b0);
    issue(1'b1, 4'b0010, 64'h7F, 64'h01, 1'b0);
    issue(1'b1, 4'b1001, 64'hFF, 64'hFF, 1'b0);

    // Randomised cases, occasional zero divisor
    for (int i = 0; i < 40; i++)
      issue(1'b1, optab[$urandom_range(0, 11)], rnd64(),
            ($urandom_range(0, 4) == 0) ? 64'd0 : rnd64(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++)
      issue(1'b0, optab[$urandom_range(0, 11)], rnd64(),
            ($urandom_range(0, 4) == 0) ? 64'd0 : rnd64(), 1'($urandom_range(0, 1)));

    // Abort a multiply with reset partway through
    issue(1'b0, 4'b1000, 64'hDEAD_BEEF, 64'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'b1001, 64'd5, 64'd9);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", bz64, 1);
    reset = 1'b1;
    #1;
    chk("abort_result", r64, 64'd0);
    chk("abort_zero",   z64, 1);
    chk("abort_busy",   bz64, 0);
    chk("abort_done",   dn64, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1'b0, 4'b0010, 64'd3, 64'd4, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
